// File: rtl/seqdet_pkg.sv
// Shared constants, FSM state type and helpers for the programmable serial
// pattern detector family.
package seqdet_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);
    localparam int DEF_CNT_W   = 16;

    localparam logic [DEF_MAX_LEN-1:0] DEF_RST_PATTERN = 8'b0000_1011;
    localparam int                     DEF_RST_LEN     = 4;
    localparam bit                     DEF_RST_OVERLAP = 1'b1;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } det_state_t;

    function automatic logic len_legal(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// an increment on the same edge.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Holding at all-ones keeps a flooded event line from wrapping to a small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: shifts qualified bits into a
// history register and pulses match when the newest len bits equal the pattern.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int                 RST_LEN     = DEF_RST_LEN,
    parameter bit                 RST_OVERLAP = DEF_RST_OVERLAP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    det_state_t         state_q;

    logic               cfg_legal;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_adv;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    det_state_t         state_n;
    logic               hit;
    logic               match_n;
    logic               cfg_err_n;

    // State register: active configuration, history, fill level and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= FILLING;
        end else begin
            if (cfg_we && cfg_legal) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
            end
            hist_q  <= hist_n;
            fill_q  <= fill_n;
            state_q <= state_n;
        end
    end

    // Next state. ARMED means the history already holds len valid bits, so a
    // new bit keeps it full; a non-overlapping hit discards the history.
    always_comb begin
        cfg_legal = len_legal(int'(cfg_len), MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
        fill_adv   = (state_q == ARMED) ? len_q : fill_q + LEN_W'(1);

        hist_n  = hist_q;
        fill_n  = fill_q;
        state_n = state_q;
        hit     = 1'b0;

        if (cfg_we) begin
            if (cfg_legal) begin
                hist_n  = '0;
                fill_n  = '0;
                state_n = FILLING;
            end
        end else if (in_valid) begin
            hist_n = hist_shift;
            fill_n = fill_adv;
            hit    = (fill_adv == len_q) &&
                     ((hist_shift & len_mask) == (pattern_q & len_mask));
            if (hit && !overlap_q) begin
                fill_n = '0;
            end
            state_n = (fill_n == len_q) ? ARMED : FILLING;
        end
    end

    // Output decode feeding the registered pulse outputs.
    always_comb begin
        match_n   = hit;
        cfg_err_n = cfg_we && !cfg_legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= match_n;
            cfg_err <= cfg_err_n;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised self-checking bench for seq_detector_param against a bit-queue
// reference model; a second instance with a 2-bit counter exercises saturation.
module tb_seq_detector_param;
    import seqdet_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               count_clr;
    logic               match;
    logic [15:0]        match_count;
    logic               cfg_err;
    logic               match_c2;
    logic [1:0]         count_c2;
    logic               cfg_err_c2;

    int checks = 0;
    int passes = 0;

    // Reference model: configuration plus the raw received bits, oldest first.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 hq[$];
    int                 m_cnt;
    int                 m_cnt2;
    bit                 m_match;
    bit                 m_err;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    seq_detector_param #(
        .CNT_W (2)
    ) dut_c2 (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .count_clr   (count_clr),
        .match       (match_c2),
        .match_count (count_c2),
        .cfg_err     (cfg_err_c2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic modelReset();
        m_pat   = DEF_RST_PATTERN;
        m_len   = DEF_RST_LEN;
        m_ovl   = DEF_RST_OVERLAP;
        hq.delete();
        m_cnt   = 0;
        m_cnt2  = 0;
        m_match = 0;
        m_err   = 0;
    endtask

    // Hit when the newest m_len received bits read, newest first, as pattern[0], pattern[1], ...
    task automatic modelStep();
        bit hit;
        hit     = 0;
        m_err   = 0;
        if (cfg_we) begin
            if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                hq.delete();
            end else begin
                m_err = 1;
            end
        end else if (in_valid) begin
            hq.push_back(in_bit);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            if (hq.size() >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (hq[hq.size() - 1 - k] != m_pat[k]) hit = 0;
            end
            if (hit && !m_ovl) hq.delete();
        end
        if (count_clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_match = hit;
    endtask

    task automatic checkAll();
        checkOutput("match", match, m_match);
        checkOutput("cfg_err", cfg_err, m_err);
        checkOutput("match_count", match_count, m_cnt);
        checkOutput("match_count_c2", count_c2, m_cnt2);
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] pat, input logic [3:0] len,
                                 input logic ovl, input logic valid, input logic b,
                                 input logic clr);
        cfg_we      = we;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = valid;
        in_bit      = b;
        count_clr   = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic resetMidCycle();
        @(posedge clk);
        #3;
        cfg_we = 0; in_valid = 0; count_clr = 0;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit s1[7];
        bit s3[4];
        s1 = '{1, 0, 1, 1, 0, 1, 1};
        s3 = '{1, 1, 0, 1};
        reset = 1'b1;
        cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        in_valid = 0; in_bit = 0; count_clr = 0;
        #12;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;

        foreach (s1[i]) sendBit(s1[i]);
        idle();
        checkOutput("plan_overlap_count", match_count, 2);

        applyStimulus(1'b1, 8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (s1[i]) sendBit(s1[i]);
        idle();
        checkOutput("plan_nonoverlap_count", match_count, 3);

        applyStimulus(1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        foreach (s3[i]) begin
            sendBit(s3[i]);
            idle();
        end
        checkOutput("plan_len1_count", match_count, 6);

        applyStimulus(1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("plan_err_len0", cfg_err, 1);
        applyStimulus(1'b1, 8'hFF, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("plan_err_len9", cfg_err, 1);
        sendBit(1); sendBit(0); sendBit(1); sendBit(1);
        checkOutput("plan_after_err_match", match, 1);

        applyStimulus(1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sendBit(1);
        checkOutput("plan_c2_saturated", count_c2, 3);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("plan_clr_wins", match_count, 0);

        resetMidCycle();
        sendBit(1); sendBit(0); sendBit(1);
        resetMidCycle();
        sendBit(1);
        checkOutput("plan_reset_no_match", match, 0);
        sendBit(0); sendBit(1); sendBit(1);
        sendBit(1); sendBit(0); sendBit(1); sendBit(1);

        for (int n = 0; n < 3000; n++) begin
            logic       we;
            logic [3:0] len;
            we  = ($urandom_range(0, 99) < 4);
            len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
            if ($urandom_range(0, 599) == 0) begin
                resetMidCycle();
            end else begin
                applyStimulus(we, 8'($urandom), len, 1'($urandom),
                              ($urandom_range(0, 9) < 7), 1'($urandom),
                              ($urandom_range(0, 99) < 3));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
